// File: rtl/npc_pkg.sv
// Shared types and default addresses for the next-PC generator.
package npc_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_J    = 4'd2,
        BR_JR   = 4'd3,
        BR_BNE  = 4'd4,
        BR_ERET = 4'd5,
        BR_BLEZ = 4'd6,
        BR_BGTZ = 4'd7,
        BR_BLTZ = 4'd8,
        BR_BGEZ = 4'd9
    } br_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI  = 32'h0000_6FFC;

endpackage

// File: rtl/npc_cond.sv
// Combinational taken/target evaluation for decode-stage branches, jumps and eret.
module npc_cond
    import npc_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [3:0]      br_type,
    input  logic [PC_W-1:0] pc_d,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] rt_val,
    input  logic [PC_W-1:0] epc,
    output logic            taken,
    output logic [PC_W-1:0] target
);

    logic            rs_neg;
    logic            rs_zero;
    logic [PC_W-1:0] br_target;

    assign rs_neg    = rs_val[PC_W-1];
    assign rs_zero   = (rs_val == '0);
    assign br_target = pc_d + PC_W'(4) + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (br_type)
            BR_BEQ:  taken = (rs_val == rt_val);
            BR_BNE:  taken = (rs_val != rt_val);
            BR_BLEZ: taken = rs_neg | rs_zero;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = !rs_neg;
            BR_J: begin
                taken  = 1'b1;
                target = {pc_d[PC_W-1:PC_W-4], addr26, 2'b00};
            end
            BR_JR: begin
                taken  = 1'b1;
                target = rs_val;
            end
            BR_ERET: begin
                taken  = 1'b1;
                target = epc;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/npc_unit.sv
// Fetch PC register with prioritised next-PC selection and a one-entry redirect
// buffer that holds a taken redirect until the fetch stall releases.
module npc_unit
    import npc_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
    parameter logic [31:0] IMEM_LO  = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI  = DEF_IMEM_HI
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_f,
    input  logic            dec_valid,
    input  logic [3:0]      br_type,
    input  logic [PC_W-1:0] pc_d,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] rt_val,
    input  logic [PC_W-1:0] epc,
    input  logic            exc_req,
    output logic [PC_W-1:0] pc_f,
    output logic            redirect,
    output logic            pend_valid,
    output logic            adel_f,
    output state_t          fsm_state
);

    // Handshake: dec_valid marks a fresh decode instruction for exactly one cycle
    // and is never back-pressured; stall_f only gates when a redirect may reach pc_f.
    // A redirect that meets a stall is parked in pend_pc, so nothing is dropped.

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt, pend_pc, pend_nxt;
    logic            redirect_nxt;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            dec_taken;

    npc_cond #(.PC_W(PC_W)) u_cond (
        .br_type (br_type),
        .pc_d    (pc_d),
        .imm16   (imm16),
        .addr26  (addr26),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .epc     (epc),
        .taken   (taken),
        .target  (target)
    );

    assign dec_taken = dec_valid & taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            pc_f     <= PC_W'(RESET_PC);
            pend_pc  <= '0;
            redirect <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_f     <= pc_nxt;
            pend_pc  <= pend_nxt;
            redirect <= redirect_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_f;
        pend_nxt     = pend_pc;
        redirect_nxt = 1'b0;
        if (exc_req) begin
            pc_nxt       = PC_W'(EXC_VEC);
            state_nxt    = RUN;
            redirect_nxt = 1'b1;
        end else if (dec_taken) begin
            if (!stall_f) begin
                pc_nxt       = target;
                state_nxt    = RUN;
                redirect_nxt = 1'b1;
            end else begin
                // newest redirect replaces anything already parked
                pend_nxt  = target;
                state_nxt = HELD;
            end
        end else if (state == HELD && !stall_f) begin
            pc_nxt       = pend_pc;
            state_nxt    = RUN;
            redirect_nxt = 1'b1;
        end else if (!stall_f) begin
            pc_nxt = pc_f + PC_W'(4);
        end
    end

    assign pend_valid = (state == HELD);
    assign fsm_state  = state;
    assign adel_f     = (pc_f[1:0] != 2'b00) || (pc_f < PC_W'(IMEM_LO)) || (pc_f > PC_W'(IMEM_HI));

endmodule

// File: doc/npc_unit.md
# npc_unit

Next-PC generator and fetch program-counter register for the pipelined MIPS core. It is the registered successor to the combinational jump-target mux. It owns `pc_f` and resolves next-PC sources in a fixed priority: exception, eret, decode-stage branches and jumps, then sequential fetch. It buffers a redirect that arrives while fetch is stalled, and flags misaligned or out-of-range fetch addresses. It sits between the decode-stage comparator/CP0 and the instruction memory.

## Interface
- `PC_W`, 32: PC width. Must be 32 while `j`/`jal` use bits [31:28].
- `RESET_PC`, 32'h0000_3000: `pc_f` value after reset.
- `EXC_VEC`, 32'h0000_4180: exception handler entry.
- `IMEM_LO`, 32'h0000_3000: lowest legal fetch address.
- `IMEM_HI`, 32'h0000_6FFC: highest legal fetch address.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `stall_f` in 1: hold fetch. `pc_f` does not advance.
- `dec_valid` in 1: the decode stage holds a new instruction this cycle. Asserted for exactly one cycle per instruction.
- `br_type` in 4: `npc_pkg::br_t` value. Encodings: NONE=0, BEQ=1, J=2, JR=3, BNE=4, ERET=5, BLEZ=6, BGTZ=7, BLTZ=8, BGEZ=9. Encodings 10–15 are treated as NONE.
- `pc_d` in PC_W: PC of the decode-stage instruction.
- `imm16` in 16: branch offset.
- `addr26` in 26: jump index.
- `rs_val` in PC_W: forwarded rs value.
- `rt_val` in PC_W: forwarded rt value.
- `epc` in PC_W: EPC from CP0.
- `exc_req` in 1: exception or interrupt request from CP0.
- `pc_f` out PC_W: current fetch address.
- `redirect` out 1: `pc_f` was loaded from a non-sequential source on the previous edge.
- `pend_valid` out 1: a redirect is buffered and waiting for the stall to release.
- `adel_f` out 1: `pc_f[1:0]!=0`, or `pc_f` is outside [IMEM_LO, IMEM_HI].

## Operation
- Taken condition, evaluated only when `dec_valid=1`:
  - BEQ: `rs_val==rt_val`. BNE: `rs_val!=rt_val`.
  - BLEZ: `rs_val` signed <=0. BGTZ: signed >0. BLTZ: `rs_val[31]`. BGEZ: `!rs_val[31]`.
  - J, JR and ERET are always taken.
- Target:
  - Branches: `pc_d + 4 + (sext(imm16)<<2)`, 32-bit wrap.
  - J: `{pc_d[31:28], addr26, 2'b00}`. This is the true MIPS form; the old zero-high-bits form is retired.
  - JR: `rs_val`. ERET: `epc`.
- Next-PC priority, highest first:
  1. `exc_req`: load EXC_VEC. This overrides `stall_f` and clears pending.
  2. Decode redirect (taken): if `stall_f=0`, load the target. Else latch the target into the pending buffer.
  3. Pending valid and `stall_f=0`: load the pending target, clear pending.
  4. `stall_f=0`: load `pc_f+4`.
  5. Otherwise hold `pc_f`.
- States:
  - RUN: pending empty.
  - HELD: pending valid.
- Transitions:
  - RUN→HELD on a taken redirect with `stall_f=1`.
  - HELD→RUN on `stall_f=0` (pending loaded) or on `exc_req`.
  - In HELD, a new taken redirect overwrites the pending target, newest wins. HELD is kept while the stall persists; the new target is loaded directly if `stall_f=0`.
- `redirect=1` for one cycle after any edge where `pc_f` was loaded by rules 1–3.
- `adel_f` is combinational from `pc_f`. This block never suppresses fetch; CP0 decides what to do with the flag.
- Reset values: `pc_f=RESET_PC`, `pend_valid=0`, state RUN, `redirect=0`.

## Timing
- One-cycle latency: a decision made in cycle N appears on `pc_f` after edge N+1.
- Delay slot: the instruction already fetched at `pc_d+4` is not cancelled; its squash is the pipeline's responsibility.
- `exc_req` and `dec_valid` in the same cycle: the exception wins and the decode target is discarded.
- `reset_n` low mid-operation: all state returns to reset values immediately; the pending buffer is lost.
- `pc_f+4` at 32'hFFFF_FFFC wraps to 0, and `adel_f` asserts.

## Structure
- `npc_pkg`: `br_t` enum, `RESET_PC`/`EXC_VEC` defaults, state enum {RUN, HELD}.
- Sub-module `npc_cond`: combinational taken/target evaluator. Inputs are `br_type`, `pc_d`, `imm16`, `addr26`, `rs_val`, `rt_val`, `epc`. Outputs are `taken` and `target`. `npc_unit` holds the registers and priority.

## Test plan
- Reset release, no stall, 4 cycles → `pc_f` = 0x3000, 0x3004, 0x3008, 0x300C; `redirect=0`.
- BNE, `pc_d`=0x3010, imm16=0xFFFC, rs=1, rt=2 → next `pc_f`=0x3004, `redirect=1` for 1 cycle. Same with rs=rt → sequential.
- J, `pc_d`=0x3020, addr26=0x0000C10 → `pc_f`=0x3040. BLTZ with rs=0x8000_0000, imm16=2 → target `pc_d`+12.
- JR rs=0x3100 with `stall_f=1` for 3 cycles → `pend_valid=1`, `pc_f` held; on stall drop → `pc_f`=0x3100, `pend_valid=0`.
- `exc_req` with a taken BEQ and `stall_f=1` in the same cycle → `pc_f`=0x4180, pending clear. Then ERET with epc=0x3058 → `pc_f`=0x3058.
- JR rs=0x3002 → `adel_f=1`. JR rs=0x7000 → `adel_f=1`. Assert `reset_n` low while HELD → immediately `pc_f`=0x3000, `pend_valid=0`.
